time_set_ctrl: RTL

Mode and time-set controller for the digital clock. It owns the time-set registers and sequences the BCD counter chain between running and setting. It turns debounced button levels into field selection, increment/decrement with wrap, and auto-repeat, then commits the edited time with a one-cycle load strobe. It sits between the button debouncers and the counter chain / seven-segment mux.

---
 rtl/time_set_ctrl_pkg.sv | 61 ++++++
 rtl/time_set_ctrl_if.sv | 24 ++
 rtl/time_set_ctrl_btn_repeat.sv | 58 +++++
 rtl/time_set_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/time_set_ctrl_pkg.sv
// Shared types, field indices, maxima and 18-bit time-word layout for time_set_ctrl.
package time_set_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_SET  = 2'd2
  } state_t;

  localparam logic [2:0] SEL_OSEC = 3'd0;
  localparam logic [2:0] SEL_TSEC = 3'd1;
  localparam logic [2:0] SEL_OMIN = 3'd2;
  localparam logic [2:0] SEL_TMIN = 3'd3;
  localparam logic [2:0] SEL_HR   = 3'd4;
  localparam int unsigned NUM_FIELDS = 5;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  localparam int unsigned TIME_W    = 18;
  localparam int unsigned OSEC_LSB  = 0;
  localparam int unsigned TSEC_LSB  = 4;
  localparam int unsigned OMIN_LSB  = 7;
  localparam int unsigned TMIN_LSB  = 11;
  localparam int unsigned HR_LSB    = 14;
  localparam int unsigned ONES_W    = 4;
  localparam int unsigned TENS_W    = 3;

  function automatic logic [3:0] get_field(input logic [TIME_W-1:0] t, input logic [2:0] s);
    case (s)
      SEL_OSEC: return t[OSEC_LSB +: ONES_W];
      SEL_TSEC: return {1'b0, t[TSEC_LSB +: TENS_W]};
      SEL_OMIN: return t[OMIN_LSB +: ONES_W];
      SEL_TMIN: return {1'b0, t[TMIN_LSB +: TENS_W]};
      default:  return t[HR_LSB +: ONES_W];
    endcase
  endfunction

  function automatic logic [TIME_W-1:0] put_field(input logic [TIME_W-1:0] t, input logic [2:0] s,
                                                  input logic [3:0] v);
    logic [TIME_W-1:0] r;
    r = t;
    case (s)
      SEL_OSEC: r[OSEC_LSB +: ONES_W] = v;
      SEL_TSEC: r[TSEC_LSB +: TENS_W] = v[2:0];
      SEL_OMIN: r[OMIN_LSB +: ONES_W] = v;
      SEL_TMIN: r[TMIN_LSB +: TENS_W] = v[2:0];
      default:  r[HR_LSB +: ONES_W]   = v;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] field_max(input logic [2:0] s, input logic [3:0] hr_max);
    case (s)
      SEL_OSEC, SEL_OMIN: return ONES_MAX;
      SEL_TSEC, SEL_TMIN: return TENS_MAX;
      default:            return hr_max;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button inputs, running time and set-time outputs of time_set_ctrl.
interface time_set_ctrl_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_mode;
  logic [17:0] live_time;
  logic [17:0] set_time;
  logic        load;
  logic        run_en;
  logic [2:0]  sel;
  logic [4:0]  blink_mask;

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_mode, live_time,
    output set_time, load, run_en, sel, blink_mask
  );

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_mode, live_time,
    input  set_time, load, run_en, sel, blink_mask
  );
endinterface

// File: rtl/time_set_ctrl_btn_repeat.sv
// Rising-edge detect plus hold/auto-repeat strobe for one button.
// Repeat counter present only with TIME_SET_AUTOREPEAT_EN defined.
module btn_repeat
`ifdef TIME_SET_AUTOREPEAT_EN
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic level_i,
`ifdef TIME_SET_AUTOREPEAT_EN
  input  logic other_i,
  input  logic clr_i,
  output logic rpt_o,
`endif
  output logic edge_o
);

  logic prev_q;

  assign edge_o = level_i & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level_i;
  end

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int unsigned CW = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          rep_q;
  logic          active;

  // cnt_q equals cycles since the press edge, so the first strobe lands HOLD_CYCLES later
  assign active = level_i & ~other_i & ~clr_i;
  assign rpt_o  = active & (cnt_q == (rep_q ? CW'(REPEAT_CYCLES) : CW'(HOLD_CYCLES)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else if (!active) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else if (rpt_o) begin
      cnt_q <= CW'(1);
      rep_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Mode / time-set controller: RUN, SET editing with wrap and blink, LOAD commit strobe.
// Optional auto-repeat of up/down under TIME_SET_AUTOREPEAT_EN.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int unsigned HR_MAX        = 12,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned BLINK_CYCLES  = 25_000_000
)(
  input  logic CLK100MHZ,
  input  logic rst,
  time_set_ctrl_if.slave bus
);

  localparam logic [3:0]  HR_MAX_L = 4'(HR_MAX);
  localparam int unsigned BW       = $clog2(BLINK_CYCLES + 1);

  state_t            state_q;
  logic [TIME_W-1:0] set_time_q, set_time_d, snap;
  logic [2:0]        sel_q, sel_d;
  logic              load_q, run_en_q;
  logic [BW-1:0]     blink_cnt_q;
  logic              phase_q;
  logic              left_prev_q, right_prev_q, mode_prev_q;

  logic up_e, up_r, dn_e, dn_r, left_e, right_e, mode_e;
  logic in_set, adj_ok, sel_chg, inc, dec, blink_clr;
  logic [3:0] fld, fmax, fld_d;

  assign left_e  = bus.btn_left  & ~left_prev_q;
  assign right_e = bus.btn_right & ~right_prev_q;
  assign mode_e  = bus.btn_mode  & ~mode_prev_q;
  assign in_set  = (state_q == ST_SET);

`ifdef TIME_SET_AUTOREPEAT_EN
  btn_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
    .clk(CLK100MHZ), .rst(rst), .level_i(bus.btn_up), .other_i(bus.btn_down),
    .clr_i(~in_set | sel_chg), .rpt_o(up_r), .edge_o(up_e)
  );
  btn_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dn (
    .clk(CLK100MHZ), .rst(rst), .level_i(bus.btn_down), .other_i(bus.btn_up),
    .clr_i(~in_set | sel_chg), .rpt_o(dn_r), .edge_o(dn_e)
  );
`else
  btn_repeat u_up (.clk(CLK100MHZ), .rst(rst), .level_i(bus.btn_up),   .edge_o(up_e));
  btn_repeat u_dn (.clk(CLK100MHZ), .rst(rst), .level_i(bus.btn_down), .edge_o(dn_e));
  assign up_r = 1'b0;
  assign dn_r = 1'b0;
`endif

  always_comb begin
    adj_ok  = in_set & ~mode_e;
    sel_chg = adj_ok & (left_e ^ right_e);
    sel_d   = sel_q;
    if (sel_chg) begin
      if (left_e) sel_d = (sel_q == SEL_HR)   ? SEL_OSEC : sel_q + 3'd1;
      else        sel_d = (sel_q == SEL_OSEC) ? SEL_HR   : sel_q - 3'd1;
    end

    // adjust always targets the pre-change field
    fld   = get_field(set_time_q, sel_q);
    fmax  = field_max(sel_q, HR_MAX_L);
    inc   = adj_ok & (up_e | up_r);
    dec   = adj_ok & (dn_e | dn_r);
    fld_d = fld;
    if (inc && !dec)      fld_d = (fld >= fmax) ? 4'd0 : fld + 4'd1;
    else if (dec && !inc) fld_d = (fld == 4'd0) ? fmax : fld - 4'd1;
    set_time_d = put_field(set_time_q, sel_q, fld_d);

    snap = bus.live_time;
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      if (get_field(bus.live_time, 3'(i)) > field_max(3'(i), HR_MAX_L))
        snap = put_field(snap, 3'(i), 4'd0);
    end

    blink_clr = sel_chg | ((state_q == ST_RUN) & mode_e);
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      set_time_q   <= '0;
      sel_q        <= SEL_OSEC;
      load_q       <= 1'b0;
      run_en_q     <= 1'b0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      mode_prev_q  <= 1'b0;
    end else begin
      left_prev_q  <= bus.btn_left;
      right_prev_q <= bus.btn_right;
      mode_prev_q  <= bus.btn_mode;

      if (blink_clr) begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end

      case (state_q)
        ST_LOAD: begin
          load_q   <= 1'b1;
          run_en_q <= 1'b0;
          state_q  <= ST_RUN;
        end
        ST_RUN: begin
          load_q   <= 1'b0;
          run_en_q <= 1'b1;
          if (mode_e) begin
            state_q    <= ST_SET;
            run_en_q   <= 1'b0;
            sel_q      <= SEL_OSEC;
            set_time_q <= snap;
          end
        end
        ST_SET: begin
          if (mode_e) begin
            state_q <= ST_LOAD;
          end else begin
            set_time_q <= set_time_d;
            sel_q      <= sel_d;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.set_time   = set_time_q;
  assign bus.load       = load_q;
  assign bus.run_en     = run_en_q;
  assign bus.sel        = sel_q;
  assign bus.blink_mask = (in_set && phase_q) ? (5'b00001 << sel_q) : '0;

endmodule
